// File: rtl/config_frame_pkg.sv
// rtl/config_frame_pkg.sv - shared constants and state encoding for the frame writer
package config_frame_pkg;

  localparam logic [31:0] SYNC_WORD = 32'hFAB0_FAB1;
  localparam logic [7:0]  OP_WRITE  = 8'h01;
  localparam logic [7:0]  OP_END    = 8'h00;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HEADER = 3'd1,
    DATA   = 3'd2,
    SETUP  = 3'd3,
    STROBE = 3'd4,
    HOLD   = 3'd5
  } state_t;

endpackage

// File: rtl/frame_strobe_decoder.sv
// rtl/frame_strobe_decoder.sv - registered binary-to-one-hot FrameStrobe driver
module frame_strobe_decoder #(
  parameter int Lines = 20,
  parameter int IdxW  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [IdxW-1:0]  index,
  output logic [Lines-1:0] strobe
);

  // Strobe comes straight from this register; clear wins so a pulse can never stick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      strobe <= '0;
    end else if (clear) begin
      strobe <= '0;
    end else if (load) begin
      strobe <= Lines'(1) << index;
    end
  end

endmodule

// File: rtl/config_frame_writer.sv
// rtl/config_frame_writer.sv - config word stream to frame latch data/strobe sequencer
module config_frame_writer
  import config_frame_pkg::*;
#(
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int StrobeCycles    = 2
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [FrameBitsPerRow-1:0] WriteData,
  input  logic                       WriteValid,
  output logic                       WriteReady,
  output logic [FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic                       Busy,
  output logic                       Done,
  output logic                       Error
);

  localparam int          IdxW      = (MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1;
  localparam logic [3:0]  CntStart  = 4'(StrobeCycles);
  localparam logic [15:0] IdxLimit  = 16'(MaxFramesPerCol);

  state_t          state;
  state_t          state_next;
  logic [IdxW-1:0] frame_idx;
  logic [3:0]      cnt;
  logic            accept;
  logic            load_idx;
  logic            load_data;
  logic            cnt_load;
  logic            cnt_dec;
  logic            strobe_load;
  logic            strobe_clear;
  logic            done_next;
  logic            error_next;

  assign WriteReady = (state == IDLE) || (state == HEADER) || (state == DATA);
  assign Busy       = (state != IDLE);
  assign accept     = WriteValid && WriteReady;

  // State register; reset lands in IDLE immediately so Busy drops and WriteReady rises.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and per-cycle control decode.
  always_comb begin
    state_next   = state;
    load_idx     = 1'b0;
    load_data    = 1'b0;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    strobe_load  = 1'b0;
    strobe_clear = 1'b0;
    done_next    = 1'b0;
    error_next   = 1'b0;
    case (state)
      IDLE: begin
        if (accept && (WriteData == SYNC_WORD)) begin
          state_next = HEADER;
        end
      end
      HEADER: begin
        if (accept) begin
          state_next = IDLE;
          if (WriteData[31:24] == OP_WRITE) begin
            if (WriteData[15:0] < IdxLimit) begin
              load_idx   = 1'b1;
              state_next = DATA;
            end else begin
              error_next = 1'b1;
            end
          end else if (WriteData[31:24] == OP_END) begin
            done_next = 1'b1;
          end else begin
            error_next = 1'b1;
          end
        end
      end
      DATA: begin
        if (accept) begin
          load_data  = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP: begin
        cnt_load   = 1'b1;
        state_next = STROBE;
      end
      STROBE: begin
        // First STROBE edge raises the line; the edge where the count hits zero drops it,
        // giving exactly StrobeCycles high cycles after the data-stable SETUP window.
        cnt_dec = 1'b1;
        if (cnt == CntStart) begin
          strobe_load = 1'b1;
        end
        if (cnt == 4'd0) begin
          strobe_clear = 1'b1;
          state_next   = HOLD;
        end
      end
      HOLD: begin
        state_next = HEADER;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: frame data, latched index, strobe counter and the status pulses.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      FrameData <= '0;
      frame_idx <= '0;
      cnt       <= '0;
      Done      <= 1'b0;
      Error     <= 1'b0;
    end else begin
      if (load_data) begin
        FrameData <= WriteData;
      end
      if (load_idx) begin
        frame_idx <= WriteData[IdxW-1:0];
      end
      if (cnt_load) begin
        cnt <= CntStart;
      end else if (cnt_dec) begin
        cnt <= cnt - 4'd1;
      end
      Done  <= done_next;
      Error <= error_next;
    end
  end

  frame_strobe_decoder #(
    .Lines (MaxFramesPerCol),
    .IdxW  (IdxW)
  ) u_strobe (
    .clk    (CLK),
    .rst    (RESET),
    .load   (strobe_load),
    .clear  (strobe_clear),
    .index  (frame_idx),
    .strobe (FrameStrobe)
  );

endmodule

// File: tb/tb_config_frame_writer.sv
// tb/tb_config_frame_writer.sv - directed self-checking bench for config_frame_writer
module tb_config_frame_writer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] WriteData;
  logic        WriteValid;
  logic        WriteReady;
  logic [31:0] FrameData;
  logic [19:0] FrameStrobe;
  logic        Busy;
  logic        Done;
  logic        Error;

  int vectors     = 0;
  int miscompares = 0;

  config_frame_writer #(
    .MaxFramesPerCol (20),
    .FrameBitsPerRow (32),
    .StrobeCycles    (2)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .WriteData   (WriteData),
    .WriteValid  (WriteValid),
    .WriteReady  (WriteReady),
    .FrameData   (FrameData),
    .FrameStrobe (FrameStrobe),
    .Busy        (Busy),
    .Done        (Done),
    .Error       (Error)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag, input logic [31:0] fd);
    check({tag, "_fd"},     64'(FrameData),   64'(fd));
    check({tag, "_strobe"}, 64'(FrameStrobe), 64'h0);
    check({tag, "_busy"},   64'(Busy),        64'h0);
    check({tag, "_done"},   64'(Done),        64'h0);
    check({tag, "_error"},  64'(Error),       64'h0);
  endtask

  // Header + data for one frame with StrobeCycles = 2; starts with the block in HEADER.
  task automatic write_frame(input string tag, input logic [15:0] idx,
                             input logic [31:0] data, input logic [19:0] exp);
    WriteValid = 1'b1;
    WriteData  = {8'h01, 8'h00, idx};
    step();
    check({tag, "_hdr_busy"},  64'(Busy),       64'h1);
    check({tag, "_hdr_ready"}, 64'(WriteReady), 64'h1);
    WriteData = data;
    step();  // edge N
    check({tag, "_n0_fd"},     64'(FrameData),   64'(data));
    check({tag, "_n0_strobe"}, 64'(FrameStrobe), 64'h0);
    check({tag, "_n0_ready"},  64'(WriteReady),  64'h0);
    WriteData = 32'h0BAD_0BAD;
    step();  // N+1
    check({tag, "_n1_strobe"}, 64'(FrameStrobe), 64'h0);
    check({tag, "_n1_fd"},     64'(FrameData),   64'(data));
    step();  // N+2
    check({tag, "_n2_strobe"}, 64'(FrameStrobe), 64'(exp));
    step();  // N+3
    check({tag, "_n3_strobe"}, 64'(FrameStrobe), 64'(exp));
    check({tag, "_n3_fd"},     64'(FrameData),   64'(data));
    step();  // N+4 (HOLD)
    check({tag, "_n4_strobe"}, 64'(FrameStrobe), 64'h0);
    check({tag, "_n4_fd"},     64'(FrameData),   64'(data));
    check({tag, "_n4_ready"},  64'(WriteReady),  64'h0);
    step();  // N+5 (HEADER)
    check({tag, "_n5_ready"},  64'(WriteReady),  64'h1);
    check({tag, "_n5_busy"},   64'(Busy),        64'h1);
    check({tag, "_n5_strobe"}, 64'(FrameStrobe), 64'h0);
    check({tag, "_n5_fd"},     64'(FrameData),   64'(data));
    WriteValid = 1'b0;
  endtask

  task automatic send_sync();
    WriteValid = 1'b1;
    WriteData  = 32'hFAB0_FAB1;
    step();
    check("sync_busy", 64'(Busy), 64'h1);
  endtask

  task automatic send_end(input string tag);
    WriteValid = 1'b1;
    WriteData  = 32'h0000_0000;
    step();
    check({tag, "_done"},  64'(Done),  64'h1);
    check({tag, "_error"}, 64'(Error), 64'h0);
    check({tag, "_busy"},  64'(Busy),  64'h0);
    WriteValid = 1'b0;
    step();
    check({tag, "_done_clr"}, 64'(Done), 64'h0);
  endtask

  initial begin
    RESET      = 1'b1;
    WriteValid = 1'b0;
    WriteData  = 32'h0;
    #1;
    check_idle_outputs("rst_hold", 32'h0);
    step();
    step();
    RESET = 1'b0;
    check("rst_ready", 64'(WriteReady), 64'h1);

    // Words without a sync are ignored.
    WriteValid = 1'b1;
    WriteData  = 32'h0100_0003;
    step();
    check_idle_outputs("nosync1", 32'h0);
    WriteData = 32'h1234_5678;
    step();
    check_idle_outputs("nosync2", 32'h0);
    WriteValid = 1'b0;
    step();

    // Single write to frame 5 then end.
    send_sync();
    write_frame("w5", 16'd5, 32'hDEAD_BEEF, 20'h00020);
    send_end("end1");

    // Out-of-range index raises Error for one cycle.
    send_sync();
    WriteData = 32'h0100_0014;
    step();
    check("badidx_error",  64'(Error),       64'h1);
    check("badidx_done",   64'(Done),        64'h0);
    check("badidx_busy",   64'(Busy),        64'h0);
    check("badidx_strobe", 64'(FrameStrobe), 64'h0);
    WriteData = 32'h0100_0000;
    step();
    check("badidx_err_clr", 64'(Error), 64'h0);
    check_idle_outputs("badidx_discard", 32'hDEAD_BEEF);
    WriteValid = 1'b0;
    step();
    check("badidx_idle", 64'(Busy), 64'h0);

    // Unknown opcode after sync.
    send_sync();
    WriteData = 32'h7700_0001;
    step();
    check("badop_error", 64'(Error), 64'h1);
    check("badop_busy",  64'(Busy),  64'h0);
    WriteValid = 1'b0;
    step();

    // Back-to-back writes to the first and last frame, then end.
    send_sync();
    write_frame("w0",  16'd0,  32'hA5A5_A5A5, 20'h00001);
    write_frame("w19", 16'd19, 32'h5A5A_5A5A, 20'h80000);
    send_end("end2");

    // Reset lands between edges while the strobe is high.
    send_sync();
    WriteData = 32'h0100_0005;
    step();
    WriteData = 32'hCAFE_F00D;
    step();
    WriteValid = 1'b0;
    step();
    step();
    check("midrst_pre_strobe", 64'(FrameStrobe), 64'h00020);
    #2;
    RESET = 1'b1;
    #1;
    check_idle_outputs("midrst", 32'h0);
    step();
    RESET = 1'b0;
    check("midrst_ready", 64'(WriteReady), 64'h1);
    send_sync();
    write_frame("w3", 16'd3, 32'h1357_9BDF, 20'h00008);
    send_end("end3");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/config_frame_writer.md
Name: config_frame_writer

Overview:
- Configuration-side driver of the tile frame latches: consumes a 32-bit configuration word stream and produces FrameData plus a one-hot, glitch-free FrameStrobe pulse per frame write.
- Sits between the configuration port (UART/bitbang FSM) and a tile column's frame latch array.
- Guarantees latch setup and hold by sequencing data-stable, strobe-high and strobe-low-with-data-held phases.

Parameters:
- MaxFramesPerCol, 20, number of FrameStrobe lines (frames per column).
- FrameBitsPerRow, 32, FrameData width and stream word width.
- StrobeCycles, 2, FrameStrobe high time in clock cycles; legal range is 1 to 15.

Ports:
- CLK  input  1  single clock.
- RESET  input  1  asynchronous, active-high reset.
- WriteData  input  FrameBitsPerRow  stream word.
- WriteValid  input  1  stream word valid.
- WriteReady  output  1  block accepts the word on the edge where WriteValid & WriteReady.
- FrameData  output  FrameBitsPerRow  registered frame data to the latches.
- FrameStrobe  output  MaxFramesPerCol  registered one-hot latch enable.
- Busy  output  1  high in every state except IDLE.
- Done  output  1  one-cycle pulse on the end command.
- Error  output  1  one-cycle pulse on a bad header.

Behaviour:
- Reset (asynchronous) forces all of the following immediately:
  - state = IDLE.
  - FrameData = 0, FrameStrobe = 0.
  - Busy = 0, Done = 0, Error = 0.
  - WriteReady = 1 once the state is IDLE.
- Reset mid-strobe drops FrameStrobe without waiting for a clock edge.
- States: IDLE, HEADER, DATA, SETUP, STROBE, HOLD.
- WriteReady = 1 in IDLE, HEADER and DATA; 0 otherwise. Words offered while WriteReady = 0 are not consumed.
- IDLE:
  - Accepted word equal to SYNC_WORD = 0xFAB0_FAB1 -> HEADER.
  - Any other word is discarded; stay in IDLE with no output change.
- HEADER, decoded on the accepted word:
  - Opcode is bits [31:24]; frame index is bits [15:0].
  - Opcode 0x01 with index < MaxFramesPerCol: latch the index -> DATA.
  - Opcode 0x01 with index >= MaxFramesPerCol: Error = 1 for the next cycle -> IDLE.
  - Opcode 0x00 (end): Done = 1 for the next cycle -> IDLE.
  - Any other opcode: Error pulse -> IDLE.
- DATA: accepted word is registered into FrameData on the same edge -> SETUP.
- SETUP:
  - One cycle; FrameData stable, FrameStrobe = 0.
  - Next edge: FrameStrobe <= one-hot(index) -> STROBE.
- STROBE:
  - FrameStrobe is held for exactly StrobeCycles cycles, counted by a down-counter.
  - The edge ending the last cycle clears FrameStrobe -> HOLD.
- HOLD: one cycle with strobe = 0 and FrameData unchanged -> HEADER.
- Latency: data accepted at edge N -> FrameStrobe high from edge N+2 to edge N+2+StrobeCycles -> WriteReady = 1 again after edge N+3+StrobeCycles.
- FrameData persists after a write; it changes only on a DATA accept or on reset.
- FrameStrobe:
  - At most one bit high at any time.
  - Driven directly from a register, never from combinational decode.
- Done and Error are never high in the same cycle. Busy returns low in the cycle Done or Error is high.
- Index arithmetic: the 16-bit index field is compared unsigned against MaxFramesPerCol; only the low bits needed for the decode are stored.

Decomposition:
- Package config_frame_pkg holds:
  - SYNC_WORD.
  - OP_WRITE = 8'h01, OP_END = 8'h00.
  - The state enum.
- One sub-module, frame_strobe_decoder:
  - Registered binary-to-one-hot decoder with load and clear inputs.
  - Asynchronously reset on RESET.
  - Owns the FrameStrobe register.

Test Plan:
- Reset: assert RESET mid-operation with no clock -> FrameData = 0, FrameStrobe = 0, Busy = 0, Done = 0, Error = 0 immediately; WriteReady = 1 after RESET deasserts.
- Single write, StrobeCycles = 2: send 0xFAB0FAB1, 0x01000005, 0xDEADBEEF with WriteValid held high.
  - FrameData = 0xDEADBEEF after the data edge N.
  - FrameStrobe = 0x00020 from edge N+2 to edge N+4, then 0.
  - FrameData still 0xDEADBEEF through HOLD.
  - WriteReady = 1 after edge N+5.
- Bad index: sync, then 0x01000014 (index 20) -> Error pulse exactly 1 cycle, FrameStrobe never nonzero, state IDLE; a following 0x01000000 is discarded.
- No sync: send 0x01000003, 0x12345678 from IDLE -> FrameStrobe stays 0, FrameData stays 0, Busy stays 0.
- Back-to-back writes, then end: sync, writes to index 0 (0xA5A5A5A5) and index 19 (0x5A5A5A5A), then 0x00000000.
  - Strobes 0x00001 and then 0x80000 seen in order, never overlapping.
  - Each strobe pulse has the matching FrameData stable one cycle before and one cycle after it.
  - Done pulses once and Busy drops.
- Reset during STROBE: assert RESET between clock edges while FrameStrobe = 0x00020 -> FrameStrobe = 0 without a clock edge; after release, a full sync/header/data sequence still completes normally.
